// File: rtl/mem_arbiter.sv
// Two-requester bus arbiter: CPU has priority, DMA is forced in after a run of
// contended CPU grants. Each grant drives the bus for ACCESS_CYCLES, then acks.
module mem_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_CPU_req,
    input  logic [18:0] i_CPU_addr,
    input  logic [15:0] i_CPU_write,
    input  logic        i_CPU_we,
    input  logic        i_CPU_be,
    output logic [15:0] o_CPU_read,
    output logic        o_CPU_ack,

    input  logic        i_DMA_req,
    input  logic [18:0] i_DMA_addr,
    input  logic [15:0] i_DMA_write,
    input  logic        i_DMA_we,
    input  logic        i_DMA_be,
    output logic [15:0] o_DMA_read,
    output logic        o_DMA_ack,

    output logic [18:0] o_BUS_addr,
    output logic [15:0] o_BUS_write,
    output logic        o_BUS_we,
    output logic        o_BUS_re,
    output logic        o_BUS_be,
    input  logic [15:0] i_BUS_read,

    output logic        o_busy
);

    localparam int CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int STREAK_W = $clog2(MAX_CPU_BURST + 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_BURST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    state_t              state_q,    state_d;
    owner_t              owner_q,    owner_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [STREAK_W-1:0] streak_q,   streak_d;
    logic [18:0]         addr_q,     addr_d;
    logic [15:0]         wdata_q,    wdata_d;
    logic                we_q,       we_d;
    logic                be_q,       be_d;
    logic [15:0]         cpu_read_q, cpu_read_d;
    logic [15:0]         dma_read_q, dma_read_d;

    logic dma_wins;

    // DMA only beats a pending CPU request once the CPU has used up its burst.
    assign dma_wins = i_DMA_req && (!i_CPU_req || (streak_q == STREAK_MAX));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_CPU;
            cnt_q      <= '0;
            streak_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= 1'b0;
            cpu_read_q <= '0;
            dma_read_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            be_q       <= be_d;
            cpu_read_q <= cpu_read_d;
            dma_read_q <= dma_read_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        be_d       = be_q;
        cpu_read_d = cpu_read_q;
        dma_read_d = dma_read_q;

        unique case (state_q)
            S_IDLE: begin
                if (dma_wins) begin
                    owner_d  = OWN_DMA;
                    addr_d   = i_DMA_addr;
                    wdata_d  = i_DMA_write;
                    we_d     = i_DMA_we;
                    be_d     = i_DMA_be;
                    cnt_d    = CNT_LOAD;
                    streak_d = '0;
                    state_d  = S_ACCESS;
                end else if (i_CPU_req) begin
                    owner_d  = OWN_CPU;
                    addr_d   = i_CPU_addr;
                    wdata_d  = i_CPU_write;
                    we_d     = i_CPU_we;
                    be_d     = i_CPU_be;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_ACCESS;
                    // Streak only grows while DMA is actually being held off.
                    if (!i_DMA_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_DMA) begin
                            dma_read_d = i_BUS_read;
                        end else begin
                            cpu_read_d = i_BUS_read;
                        end
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_BUS_addr  = '0;
        o_BUS_write = '0;
        o_BUS_we    = 1'b0;
        o_BUS_re    = 1'b0;
        o_BUS_be    = 1'b0;
        if (state_q == S_ACCESS) begin
            o_BUS_addr  = addr_q;
            o_BUS_write = wdata_q;
            o_BUS_we    = we_q;
            o_BUS_re    = !we_q;
            o_BUS_be    = be_q;
        end
    end

    assign o_CPU_ack  = (state_q == S_DONE) && (owner_q == OWN_CPU);
    assign o_DMA_ack  = (state_q == S_DONE) && (owner_q == OWN_DMA);
    assign o_CPU_read = cpu_read_q;
    assign o_DMA_read = dma_read_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule
